// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU command front-end.
//
// The ALU operand/opcode/result widths are fixed here. The command record
// (a, b, op, tag) depends on the instantiating module's TAG_W, so that struct
// is declared inside the module using these constants; the operand part
// that does not depend on the tag width lives here as alu_opnd_t.
package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_OP_W   = 4;
  localparam int ALU_RES_W  = 5;

  // Operand portion of a command; op is opaque to this block.
  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_OP_W-1:0]   op;
  } alu_opnd_t;

  // Issue FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO holding packed command words.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset (clears pointers/count)
//   push, wdata    write request and data; ignored when full
//   pop            read request; ignored when empty
//   rdata          head entry (combinational from the read pointer)
//   full, empty    status flags derived from count
//   count          number of valid entries, 0..DEPTH
//
// A push and a pop in the same cycle while not full move both pointers and
// leave count unchanged. When full, a push is refused even if a pop happens
// in the same cycle.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once the count says valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: sequential front-end for a 4-bit combinational ALU.
//
// Commands are buffered in a FIFO, issued one at a time to the ALU through
// registered operands, and the ALU's 5-bit result is captured and returned
// with the command's tag.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (cmd_ready = FIFO not full)
//   cmd_a, cmd_b, cmd_op, cmd_tag    command payload
//   alu_a, alu_b, alu_op             registered operands to the ALU
//   alu_result                       combinational ALU result
//   res_valid/res_ready              response handshake
//   res_data, res_tag                captured result and its tag
//   busy                             FSM not IDLE or FIFO non-empty
//   issued_cnt                       commands popped to the ALU, wraps
//   state_dbg                        current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A source holding valid keeps its payload stable until the
// transfer; res_valid/res_data/res_tag are held while res_ready is low.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ALU_DATA_W-1:0] cmd_a,
  input  logic [ALU_DATA_W-1:0] cmd_b,
  input  logic [ALU_OP_W-1:0]   cmd_op,
  input  logic [TAG_W-1:0]      cmd_tag,
  output logic [ALU_DATA_W-1:0] alu_a,
  output logic [ALU_DATA_W-1:0] alu_b,
  output logic [ALU_OP_W-1:0]   alu_op,
  input  logic [ALU_RES_W-1:0]  alu_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ALU_RES_W-1:0]  res_data,
  output logic [TAG_W-1:0]      res_tag,
  output logic                  busy,
  output logic [CNT_W-1:0]      issued_cnt,
  output issue_state_t          state_dbg
);

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_OP_W-1:0]   op;
    logic [TAG_W-1:0]      tag;
  } alu_cmd_t;

  localparam int CMD_W = $bits(alu_cmd_t);

  // FIFO interface
  alu_cmd_t                 fifo_wdata, fifo_head;
  logic                     fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(DEPTH):0]   fifo_count;

  // FSM and datapath registers
  issue_state_t          state_q, state_d;
  logic [ALU_DATA_W-1:0] alu_a_q, alu_b_q;
  logic [ALU_OP_W-1:0]   alu_op_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  res_valid_q, res_valid_d;
  logic [ALU_RES_W-1:0]  res_data_q, res_data_d;
  logic [TAG_W-1:0]      res_tag_q, res_tag_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  load_alu;

  assign fifo_wdata = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Commands always land in the FIFO first; there is no path from cmd_* to
  // alu_*. The FIFO itself refuses pushes while full.
  assign cmd_ready = !fifo_full;
  assign fifo_pop  = load_alu;

  always_comb begin
    state_d     = state_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    load_alu    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          load_alu = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // Operands were registered on the previous edge, so the ALU output
        // has had a full cycle to settle.
        res_valid_d = 1'b1;
        res_data_d  = alu_result;
        res_tag_d   = tag_q;
        state_d     = RESP;
      end
      RESP: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          // Chaining straight into the next command keeps the sustained
          // rate at one result every two cycles.
          if (!fifo_empty) begin
            load_alu = 1'b1;
            state_d  = EXEC;
          end else begin
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
      if (load_alu) begin
        alu_a_q  <= fifo_head.a;
        alu_b_q  <= fifo_head.b;
        alu_op_q <= fifo_head.op;
        tag_q    <= fifo_head.tag;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_tag    = res_tag_q;
  assign issued_cnt = cnt_q;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// tb_alu_cmd_issue: self-checking bench for alu_cmd_issue.
module tb_alu_cmd_issue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 3;
  localparam int CNT_W = 16;
  localparam int EW    = TAG_W + ALU_RES_W;

  logic                  clk, rst;
  logic                  cmd_valid, cmd_ready;
  logic [3:0]            cmd_a, cmd_b, cmd_op;
  logic [TAG_W-1:0]      cmd_tag;
  logic [3:0]            alu_a, alu_b, alu_op;
  logic [4:0]            alu_result;
  logic                  res_valid, res_ready;
  logic [4:0]            res_data;
  logic [TAG_W-1:0]      res_tag;
  logic                  busy;
  logic [CNT_W-1:0]      issued_cnt;
  issue_state_t          state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_since_rst = 0;
  bit rr_rand = 1'b0;
  logic [EW-1:0] exp_q[$];
  int hs_cyc[$];

  alu_cmd_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag),
    .busy(busy), .issued_cnt(issued_cnt), .state_dbg(state_dbg)
  );

  // Reference rule for the ALU: op 0 is a 5-bit add, anything else yields 0.
  function automatic logic [4:0] ref_res(input logic [3:0] a, b, op);
    int s;
    s = (op == 4'd0) ? (int'(a) + int'(b)) : 0;
    return 5'(s);
  endfunction

  always_comb alu_result = ref_res(alu_a, alu_b, alu_op);

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Offer one command for one edge; returns whether it was taken.
  task automatic send(input logic [3:0] a, b, op, input logic [TAG_W-1:0] tag, output bit acc);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    #1;
    acc = cmd_ready;
    if (acc) begin
      exp_q.push_back({tag, ref_res(a, b, op)});
      acc_since_rst++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_retry(input logic [3:0] a, b, op, input logic [TAG_W-1:0] tag);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      send(a, b, op, tag, acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=not_accepted exp=accepted tag=%0d", tag);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || res_valid || busy) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_drain_pending"}, exp_q.size(), 0);
    chk({name, "_drain_busy"}, busy, 1'b0);
  endtask

  // ---------------- scoreboard monitor ----------------
  // A response is consumed on the next rising edge whenever valid and ready
  // are both high in the quiet part of the cycle.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && res_valid && res_ready) begin
        hs_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL resp_unexpected got tag=%0d data=%0h exp=none", res_tag, res_data);
        end else begin
          e = exp_q.pop_front();
          if ({res_tag, res_data} !== e)
            begin
              errors++;
              $display("FAIL resp_order got tag=%0d data=%0h exp tag=%0d data=%0h",
                       res_tag, res_data, e[EW-1:ALU_RES_W], e[ALU_RES_W-1:0]);
            end
        end
      end
    end
  end

  always @(negedge clk) if (rr_rand) res_ready = 1'($urandom_range(0, 1));

  // ---------------- stimulus ----------------
  initial begin
    bit acc;
    int lat, nacc, bad;
    logic [6:0] mask7;
    logic [2:0] mask3;
    logic [3:0] a0, b0;
    logic [3:0] ra, rb, rop;

    rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;

    // Reset pulse mid-cycle, checked before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_alu_a", alu_a, 4'd0);
    chk("rst_alu_b", alu_b, 4'd0);
    chk("rst_alu_op", alu_op, 4'd0);
    chk("rst_res_data", res_data, 5'd0);
    chk("rst_res_tag", res_tag, 3'd0);
    chk("rst_issued_cnt", issued_cnt, 16'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready_during", cmd_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_cmd_ready_after", cmd_ready, 1'b1);

    // Single op: response on the third edge counting the accept edge.
    res_ready = 1'b1;
    send(4'b0010, 4'b0011, 4'b0000, 3'd1, acc);
    chk("single_acc", acc, 1'b1);
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("single_latency", lat, 3);
    chk("single_data", res_data, 5'b00101);
    chk("single_tag", res_tag, 3'd1);
    chk("single_issued_cnt", issued_cnt, 16'd1);
    @(posedge clk); #1;
    chk("single_valid_drop", res_valid, 1'b0);

    // Carry into bit 4.
    send(4'b1001, 4'b1011, 4'b0000, 3'd2, acc);
    lat = 1;
    while (!res_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("carry_data", res_data, 5'b10100);
    wait_drain("carry");

    // Backpressure: 7 offered, DEPTH+1 taken.
    res_ready = 1'b0;
    a0 = 4'($urandom_range(0, 15));
    b0 = 4'($urandom_range(0, 15));
    nacc = 0;
    mask7 = '0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) send(a0, b0, 4'd0, 3'd0, acc);
      else        send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'd0, 3'(i), acc);
      mask7[i] = acc;
      if (acc) nacc++;
    end
    chk("bp_accepted", nacc, 5);
    chk("bp_accept_mask", mask7, 7'b0011111);
    chk("bp_cmd_ready_full", cmd_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", res_valid, 1'b1);
      chk("bp_hold_tag", res_tag, 3'd0);
      chk("bp_hold_data", res_data, ref_res(a0, b0, 4'd0));
      @(posedge clk); #1;
    end
    hs_cyc.delete();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_cmd_ready_after_pop", cmd_ready, 1'b1);
    wait_drain("bp");
    chk("bp_resp_count", hs_cyc.size(), 5);
    for (int i = 1; i < hs_cyc.size(); i++)
      chk("bp_resp_spacing", hs_cyc[i] - hs_cyc[i-1], 2);

    // Simultaneous push and pop with two queued.
    res_ready = 1'b0;
    send(4'd1, 4'd2, 4'd0, 3'd0, acc);
    send(4'd3, 4'd4, 4'd0, 3'd1, acc);
    send(4'd5, 4'd6, 4'd0, 3'd2, acc);
    res_ready = 1'b1;
    send(4'd7, 4'd8, 4'd0, 3'd3, acc);
    chk("simul_push_acc", acc, 1'b1);
    res_ready = 1'b0;
    mask3 = '0;
    for (int i = 0; i < 3; i++) begin
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'd5, 3'(4 + i), acc);
      mask3[i] = acc;
    end
    chk("simul_fill_mask", mask3, 3'b011);
    res_ready = 1'b1;
    wait_drain("simul");

    // Reset while a response is pending and three commands are queued.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd1, 4'd1, 4'd0, 3'(i), acc);
    chk("midrst_pre_valid", res_valid, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_res_valid", res_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_alu_a", alu_a, 4'd0);
    chk("midrst_alu_op", alu_op, 4'd0);
    chk("midrst_issued_cnt", issued_cnt, 16'd0);
    chk("midrst_cmd_ready", cmd_ready, 1'b1);
    exp_q.delete();
    acc_since_rst = 0;
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (res_valid || busy) bad++;
    end
    chk("midrst_no_stale", bad, 0);

    // Randomized traffic with random backpressure.
    rr_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rop = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(0, 15));
      send_retry(ra, rb, rop, 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    @(negedge clk);
    rr_rand = 1'b0;
    res_ready = 1'b1;
    wait_drain("rand");
    chk("rand_issued_cnt", issued_cnt, 32'(acc_since_rst));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
